// File: rtl/game_pkg.sv
// Shared game constants and types for the consumers of the rand_gen word stream.
// Contents: coordinate widths, screen geometry, the position of the gap-code field
// in the random word, and the per-slot column state record.
package game_pkg;

  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned BIRD_X   = 160;

  // Gap-height code field inside the rand_gen word (bits 24:22).
  localparam int unsigned RAND_GAP_LSB = 22;
  localparam int unsigned RAND_GAP_W   = 3;

  // One obstacle column: occupancy, right-edge x, and gap-top y.
  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] gap_y;
  } slot_state_t;

endpackage

// File: rtl/pipe_spawner_if.sv
// Bus between the game controller / rand_gen and pipe_spawner.
// master: drives frame_tick, run, clear, rand_word; observes the column state and pulses.
// slave : pipe_spawner side.
interface pipe_spawner_if #(
  parameter int unsigned N_SLOTS = 4
);

  logic                              frame_tick;
  logic                              run;
  logic                              clear;
  logic [31:0]                       rand_word;
  logic [N_SLOTS-1:0]                slot_valid;
  logic [N_SLOTS*game_pkg::X_W-1:0]  slot_x;
  logic [N_SLOTS*game_pkg::Y_W-1:0]  slot_gap_y;
  logic                              spawn_pulse;
  logic                              score_pulse;
  logic                              overflow;

  modport master (
    output frame_tick, run, clear, rand_word,
    input  slot_valid, slot_x, slot_gap_y, spawn_pulse, score_pulse, overflow
  );

  modport slave (
    input  frame_tick, run, clear, rand_word,
    output slot_valid, slot_x, slot_gap_y, spawn_pulse, score_pulse, overflow
  );

endinterface

// File: rtl/pipe_slot.sv
// One obstacle column slot: holds valid/x/gap_y, scrolls left on each active tick,
// retires when the column would leave the screen, and flags a bird-crossing.
// Ports: clk, rst (async, active-high), clear (sync), tick (active frame tick),
// spawn (load a fresh column), spawn_gap_y, state (registered), cross_c (combinational).
module pipe_slot
  import game_pkg::*;
#(
  parameter int unsigned SPEED   = 2,
  parameter int unsigned BIRD_X  = game_pkg::BIRD_X,
  parameter int unsigned SPAWN_X = 692
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           tick,
  input  logic           spawn,
  input  logic [Y_W-1:0] spawn_gap_y,
  output slot_state_t    state,
  output logic           cross_c
);

  localparam logic [X_W-1:0] SPEED_X = X_W'(SPEED);
  localparam logic [X_W-1:0] BIRD_XX = X_W'(BIRD_X);
  localparam logic [X_W-1:0] START_X = X_W'(SPAWN_X);

  logic [X_W-1:0] new_x_c;
  logic           retire_c;

  // Retire before subtracting so x can never wrap below zero.
  assign new_x_c  = state.x - SPEED_X;
  assign retire_c = (state.x <= SPEED_X);
  assign cross_c  = tick & state.valid & ~retire_c & (state.x > BIRD_XX) & (new_x_c <= BIRD_XX);

  // Slot register: clear > spawn > scroll/retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (clear) begin
      state <= '0;
    end else if (spawn) begin
      state.valid <= 1'b1;
      state.x     <= START_X;
      state.gap_y <= spawn_gap_y;
    end else if (tick && state.valid) begin
      if (retire_c) state.valid <= 1'b0;
      else          state.x     <= new_x_c;
    end
  end

endmodule

// File: rtl/pipe_spawner.sv
// Obstacle column spawner: scrolls up to N_SLOTS columns once per frame, spawns a new
// column every SPAWN_PERIOD frames with a gap height taken from the random word.
// Ports: clk, rst (async, active-high), bus (pipe_spawner_if.slave): frame_tick, run,
// clear, rand_word in; slot_valid, slot_x, slot_gap_y, spawn_pulse, score_pulse,
// overflow out (all registered).
module pipe_spawner
  import game_pkg::*;
#(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned SCREEN_W     = game_pkg::SCREEN_W,
  parameter int unsigned PIPE_W       = 52,
  parameter int unsigned BIRD_X       = game_pkg::BIRD_X,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned GAP_BASE     = 80,
  parameter int unsigned GAP_STEP     = 40
) (
  input logic          clk,
  input logic          rst,
  pipe_spawner_if.slave bus
);

  localparam int unsigned CNT_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned SPAWN_X = SCREEN_W + PIPE_W;

  logic                 active_c;
  logic                 spawn_req_c;
  logic [CNT_W-1:0]     cnt;
  logic [N_SLOTS-1:0]   valid_vec;
  logic [N_SLOTS-1:0]   cross_c;
  logic [N_SLOTS-1:0]   free_onehot_c;
  logic                 any_free_c;
  logic [Y_W-1:0]       spawn_gap_c;
  logic [RAND_GAP_W-1:0] gap_code_c;
  logic                 spawn_pulse_q;
  logic                 score_pulse_q;
  logic                 overflow_q;
  logic                 rand_unused;
  slot_state_t          slot_q [N_SLOTS];

  assign active_c    = bus.frame_tick & bus.run & ~bus.clear;
  assign spawn_req_c = active_c & (cnt == '0);

  // Gap height in 9-bit arithmetic from the shared rand field.
  assign gap_code_c  = bus.rand_word[RAND_GAP_LSB +: RAND_GAP_W];
  assign spawn_gap_c = Y_W'(GAP_BASE) + Y_W'(gap_code_c) * Y_W'(GAP_STEP);
  assign rand_unused = ^{bus.rand_word[31:RAND_GAP_LSB+RAND_GAP_W], bus.rand_word[RAND_GAP_LSB-1:0]};

  // Lowest-index slot that is free before this tick; a same-tick retire is not reused.
  always_comb begin
    free_onehot_c = '0;
    any_free_c    = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (!any_free_c && !valid_vec[i]) begin
        free_onehot_c[i] = 1'b1;
        any_free_c       = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_slot
    pipe_slot #(
      .SPEED  (SPEED),
      .BIRD_X (BIRD_X),
      .SPAWN_X(SPAWN_X)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.clear),
      .tick       (active_c),
      .spawn      (spawn_req_c & free_onehot_c[g]),
      .spawn_gap_y(spawn_gap_c),
      .state      (slot_q[g]),
      .cross_c    (cross_c[g])
    );

    assign valid_vec[g]                 = slot_q[g].valid;
    assign bus.slot_x[g*X_W +: X_W]     = slot_q[g].x;
    assign bus.slot_gap_y[g*Y_W +: Y_W] = slot_q[g].gap_y;
  end

  // Spawn timer, pulses and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      spawn_pulse_q <= 1'b0;
      score_pulse_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (bus.clear) begin
      cnt           <= '0;
      spawn_pulse_q <= 1'b0;
      score_pulse_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      spawn_pulse_q <= spawn_req_c & any_free_c;
      score_pulse_q <= |cross_c;
      if (spawn_req_c && !any_free_c) overflow_q <= 1'b1;
      if (active_c) begin
        if (cnt == '0) cnt <= CNT_W'(SPAWN_PERIOD - 1);
        else           cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.slot_valid  = valid_vec;
  assign bus.spawn_pulse = spawn_pulse_q;
  assign bus.score_pulse = score_pulse_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_pipe_spawner.sv
// Bench for pipe_spawner: two instances (default timing, and fast spawn / slow scroll)
// share one stimulus stream and are compared each cycle against a frame-level model.
module tb_pipe_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] rand_word = '0;

  always #5 clk = ~clk;

  pipe_spawner_if #(.N_SLOTS(4)) ifa ();
  pipe_spawner_if #(.N_SLOTS(4)) ifb ();

  assign ifa.frame_tick = frame_tick;
  assign ifa.run        = run;
  assign ifa.clear      = clear;
  assign ifa.rand_word  = rand_word;
  assign ifb.frame_tick = frame_tick;
  assign ifb.run        = run;
  assign ifb.clear      = clear;
  assign ifb.rand_word  = rand_word;

  pipe_spawner #(.N_SLOTS(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_spawner #(.N_SLOTS(4), .SPAWN_PERIOD(2), .SPEED(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // DUT outputs gathered per instance.
  logic [3:0]  v  [2];
  logic [39:0] xs [2];
  logic [35:0] gs [2];
  logic        sp [2];
  logic        sc [2];
  logic        ov [2];
  assign v[0] = ifa.slot_valid;  assign v[1] = ifb.slot_valid;
  assign xs[0] = ifa.slot_x;     assign xs[1] = ifb.slot_x;
  assign gs[0] = ifa.slot_gap_y; assign gs[1] = ifb.slot_gap_y;
  assign sp[0] = ifa.spawn_pulse; assign sp[1] = ifb.spawn_pulse;
  assign sc[0] = ifa.score_pulse; assign sc[1] = ifb.score_pulse;
  assign ov[0] = ifa.overflow;   assign ov[1] = ifb.overflow;

  int checks = 0;
  int errors = 0;
  int score_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: per-frame rules applied to arrays of columns.
  int period [2] = '{90, 2};
  int speed  [2] = '{2, 1};
  int m_valid [2][4];
  int m_x     [2][4];
  int m_gap   [2][4];
  int m_cnt   [2];
  int m_sp    [2];
  int m_sc    [2];
  int m_ov    [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[d][i] = 0; m_x[d][i] = 0; m_gap[d][i] = 0;
      end
      m_cnt[d] = 0; m_sp[d] = 0; m_sc[d] = 0; m_ov[d] = 0;
    end
  endtask

  task automatic model_frame(input int d, input int code);
    int free;
    free = -1;
    for (int i = 0; i < 4; i++)
      if (free < 0 && m_valid[d][i] == 0) free = i;
    m_sc[d] = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[d][i] != 0) begin
        if (m_x[d][i] <= speed[d]) m_valid[d][i] = 0;
        else begin
          if (m_x[d][i] > 160 && m_x[d][i] - speed[d] <= 160) m_sc[d] = 1;
          m_x[d][i] -= speed[d];
        end
      end
    end
    m_sp[d] = 0;
    if (m_cnt[d] == 0) begin
      m_cnt[d] = period[d] - 1;
      if (free >= 0) begin
        m_valid[d][free] = 1;
        m_x[d][free]     = 640 + 52;
        m_gap[d][free]   = 80 + code * 40;
        m_sp[d]          = 1;
      end else m_ov[d] = 1;
    end else m_cnt[d]--;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || clear) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        if (frame_tick && run) model_frame(d, int'(rand_word[24:22]));
        else begin m_sp[d] = 0; m_sc[d] = 0; end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cmp%0d valid%0d", d, i), 32'(v[d][i]), m_valid[d][i]);
        chk($sformatf("cmp%0d x%0d", d, i), 32'(xs[d][i*10 +: 10]), m_x[d][i]);
        chk($sformatf("cmp%0d gap%0d", d, i), 32'(gs[d][i*9 +: 9]), m_gap[d][i]);
      end
      chk($sformatf("cmp%0d spawn", d), 32'(sp[d]), m_sp[d]);
      chk($sformatf("cmp%0d score", d), 32'(sc[d]), m_sc[d]);
      chk($sformatf("cmp%0d overflow", d), 32'(ov[d]), m_ov[d]);
    end
    if (ifa.score_pulse === 1'b1) score_a++;
  end

  function automatic logic [31:0] gap_word(input int code);
    logic [31:0] w;
    w = 32'h5a5a_5a5a;
    w[24:22] = 3'(code);
    return w;
  endfunction

  // Holds frame_tick high for n consecutive sampling edges; call right after a negedge.
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset valid", 32'(v[0]), 0);
    chk("reset x0", 32'(xs[0][9:0]), 0);
    chk("reset spawn", 32'(sp[0]), 0);
    chk("reset overflow", 32'(ov[1]), 0);

    // First active tick spawns into slot 0.
    @(negedge clk);
    run = 1'b1;
    rand_word = gap_word(3);
    ticks(1);                                   // tick 1
    chk("spawn1 valid", 32'(v[0]), 4'b0001);
    chk("spawn1 x0", 32'(xs[0][9:0]), 692);
    chk("spawn1 gap0", 32'(gs[0][8:0]), 200);
    chk("spawn1 pulse", 32'(sp[0]), 1);
    rand_word = gap_word(0);
    @(negedge clk);
    chk("spawn1 pulse ends", 32'(sp[0]), 0);

    // Periodic spawns at ticks 91 and 181.
    ticks(90);                                  // tick 91
    chk("spawn91 valid", 32'(v[0]), 4'b0011);
    chk("spawn91 gap1", 32'(gs[0][17:9]), 80);
    chk("spawn91 pulse", 32'(sp[0]), 1);
    chk("tick91 x0", 32'(xs[0][9:0]), 512);
    rand_word = gap_word(7);
    ticks(90);                                  // tick 181
    chk("spawn181 valid", 32'(v[0]), 4'b0111);
    chk("spawn181 gap2", 32'(gs[0][26:18]), 360);

    // Slot 0 crosses the bird on the 162 -> 160 step.
    ticks(85);                                  // tick 266
    chk("pre-cross x0", 32'(xs[0][9:0]), 162);
    chk("pre-cross score", 32'(sc[0]), 0);
    ticks(1);                                   // tick 267
    chk("cross x0", 32'(xs[0][9:0]), 160);
    chk("cross score", 32'(sc[0]), 1);
    ticks(79);                                  // tick 346
    chk("x0 at 2", 32'(xs[0][9:0]), 2);
    chk("score count", 32'(score_a), 1);
    ticks(1);                                   // tick 347: retire
    chk("retire valid", 32'(v[0]), 4'b1110);
    chk("retire x0 held", 32'(xs[0][9:0]), 2);
    chk("retire no score", 32'(sc[0]), 0);
    chk("b overflow", 32'(ov[1]), 1);
    chk("b no spawn", 32'(sp[1]), 0);
    chk("b all valid", 32'(v[1]), 4'b1111);

    // Freeze: ticks with run low change nothing.
    run = 1'b0;
    ticks(10);
    chk("freeze a x1", 32'(xs[0][19:10]), 180);
    chk("freeze a valid", 32'(v[0]), 4'b1110);
    chk("freeze b x0", 32'(xs[1][9:0]), 346);
    chk("freeze b overflow", 32'(ov[1]), 1);
    run = 1'b1;
    ticks(13);                                  // tick 360
    chk("tick360 no spawn", 32'(sp[0]), 0);
    ticks(1);                                   // tick 361
    chk("tick361 spawn", 32'(sp[0]), 1);
    chk("tick361 valid", 32'(v[0]), 4'b1111);
    chk("tick361 x0", 32'(xs[0][9:0]), 692);
    chk("tick361 x1", 32'(xs[0][19:10]), 152);
    @(negedge clk);
    chk("score count 2", 32'(score_a), 2);

    // Clear wins over a coincident frame tick.
    clear = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    frame_tick = 1'b0;
    chk("clear a valid", 32'(v[0]), 0);
    chk("clear b valid", 32'(v[1]), 0);
    chk("clear a spawn", 32'(sp[0]), 0);
    chk("clear b overflow", 32'(ov[1]), 0);
    chk("clear a x0", 32'(xs[0][9:0]), 0);

    // Three columns alive, then an asynchronous reset between edges.
    ticks(181);
    chk("pre-rst valid", 32'(v[0]), 4'b0111);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst a valid", 32'(ifa.slot_valid), 0);
    chk("async rst b valid", 32'(ifb.slot_valid), 0);
    chk("async rst b overflow", 32'(ifb.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    ticks(1);
    chk("post-rst spawn valid", 32'(v[0]), 4'b0001);
    chk("post-rst spawn pulse", 32'(sp[0]), 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_spawner.md
# pipe_spawner

Consumer of the `rand_gen` random word stream.
- Once per frame it scrolls up to N_SLOTS obstacle columns leftward and retires those that leave the screen.
- Every SPAWN_PERIOD frames it spawns a new column whose gap height is taken from `rand[24:22]`.
- Sits between `rand_gen` and the renderer/collision logic; exposes per-slot column state and score/spawn pulses.

## Interface
- N_SLOTS, 4, number of concurrent column slots
- SPAWN_PERIOD, 90, frames between spawns (≥2)
- SCREEN_W, 640, screen width in pixels
- PIPE_W, 52, column width in pixels
- BIRD_X, 160, bird x position; a column passing it scores
- SPEED, 2, pixels scrolled per frame (1..15)
- GAP_BASE, 80, gap y for rand code 0
- GAP_STEP, 40, gap y increment per rand code

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- run  in  1  game running; low freezes all state
- clear  in  1  synchronous restart: empties slots, reloads spawn timer
- rand  in  32  random word from `rand_gen`
- slot_valid  out  N_SLOTS  slot occupied
- slot_x  out  N_SLOTS*10  right edge of column per slot, slot i at [10i+9:10i]
- slot_gap_y  out  N_SLOTS*9  gap top y per slot, slot i at [9i+8:9i]
- spawn_pulse  out  1  one cycle when a column is spawned
- score_pulse  out  1  one cycle when any column's right edge passes BIRD_X
- overflow  out  1  sticky: spawn requested with no free slot

## Operation
- Reset and `clear`:
  - All outputs are 0.
  - Spawn counter is 0, so the first active tick spawns.
  - `clear` has priority over `frame_tick`; `overflow` is cleared only by `rst` or `clear`.
- Active tick (`frame_tick & run & !clear`), for each valid slot:
  - Compute new_x = x − SPEED.
  - If x ≤ SPEED, the slot retires (valid←0, x unchanged) and does not score.
  - Otherwise x←new_x. If x > BIRD_X and new_x ≤ BIRD_X, assert `score_pulse`. Multiple crossings in one tick yield a single pulse.
- Spawn counter on an active tick:
  - If counter == 0: reload to SPAWN_PERIOD−1 and request a spawn.
  - Otherwise decrement.
- Spawn request:
  - Target is the lowest-index slot that was invalid *before* this tick. A slot retiring on the same tick is not reusable until the next tick.
  - Spawned slot gets x = SCREEN_W + PIPE_W and gap_y = GAP_BASE + rand[24:22]·GAP_STEP, computed in 9 bits.
  - The spawned slot is not scrolled on its spawn tick.
  - If no slot is free: the spawn is dropped, `overflow`←1, and `spawn_pulse` stays low.
- `run` low: ticks are ignored and all state holds. `clear` still acts.
- Width rules:
  - SCREEN_W+PIPE_W < 1024.
  - GAP_BASE+7·GAP_STEP < 512.
  - x never underflows because of the retire rule.

## Timing
- All outputs are registered.
- State, `spawn_pulse` and `score_pulse` update on the rising edge that samples the active `frame_tick`. They are visible the next cycle, so latency is 1 cycle.
- Pulses last exactly one cycle.
- `rand` is sampled only on the spawn cycle; no handshake with `rand_gen` (a free-running source).
- `rst` asserted mid-frame clears state immediately, without a clock; the first active tick after release spawns.
- Back-to-back `frame_tick` on consecutive cycles must be handled correctly.

## Structure
- Shared package `game_pkg`:
  - X_W=10, Y_W=9
  - SCREEN_W, BIRD_X
  - the rand gap field position (bits 24:22) as a named constant, shared with other `rand_gen` consumers
- Sub-module `pipe_slot`:
  - one slot register set, with scroll/retire/score-cross logic
  - instantiated N_SLOTS times via generate
- Parent owns:
  - spawn counter
  - free-slot priority encoder
  - pulse OR-reduction
  - overflow flag

## Test plan
- **Reset spawn:** reset, run=1, one tick with rand[24:22]=3 → next cycle slot_valid=0001, slot0 x=692, gap_y=200, spawn_pulse=1 for one cycle.
- **Scroll and score:** after spawn, 266 ticks → x=160, score_pulse once on the tick x went 162→160. Continue to x=2, then one more tick → slot0 invalid, no score pulse.
- **Periodic spawn:** SPAWN_PERIOD=90 with continuous ticks → spawns on ticks 1, 91, 181 into slots 0, 1, 2. rand codes 0/7 → gap_y 80/360.
- **Overflow:** SPAWN_PERIOD=2, SPEED=1 → 5th spawn finds no free slot, overflow=1 and sticky, spawn_pulse low. After `clear`: overflow=0, slots empty.
- **Freeze:** run=0 for 10 ticks → slot_x and counter unchanged. clear=1 with frame_tick=1 → cleared, no spawn.
- **Async reset:** assert rst between clock edges with 3 slots valid → slot_valid=0 before the next edge.
